// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer FSM with return-address stack
module pc_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_ack,
  input  logic [2:0]        op_kind,
  input  logic [1:0]        op_len,
  input  logic              cond_true,
  input  logic signed [7:0] offset,
  input  logic [7:0]        target,
  input  logic [7:0]        pc,
  output logic              increment,
  output logic              branch_load,
  output logic              jmp_load,
  output logic              jsr_load,
  output logic              pc_load,
  output logic [7:0]        branch,
  output logic [7:0]        jmp_addr,
  output logic [7:0]        jsr_addr,
  output logic [7:0]        pc_addr,
  output logic              fetch_req,
  output logic              halted,
  output logic              stack_err,
  output logic [3:0]        depth
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [2:0] K_NEXT   = 3'd0;
  localparam logic [2:0] K_BRANCH = 3'd1;
  localparam logic [2:0] K_JMP    = 3'd2;
  localparam logic [2:0] K_JSR    = 3'd3;
  localparam logic [2:0] K_RTS    = 3'd4;
  localparam logic [2:0] K_HALT   = 3'd5;

  localparam logic [3:0] MAX_DEPTH = 4'(STACK_DEPTH);

  state_t     state_q, state_d;
  logic [2:0] kind_q, kind_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] depth_q, depth_d;
  logic       err_q, err_d;
  logic [7:0] stack_q [STACK_DEPTH];

  logic       push;
  logic [7:0] top;
  logic       inc_c, bl_c, jl_c, jsl_c, pl_c, fetch_c;

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == 4'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
    inc_c   = 1'b0;
    bl_c    = 1'b0;
    jl_c    = 1'b0;
    jsl_c   = 1'b0;
    pl_c    = 1'b0;
    fetch_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_c = 1'b1;
        if (fetch_ack) begin
          inc_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        kind_d  = (op_kind > K_HALT) ? K_HALT : op_kind;
        cnt_d   = (op_len == 2'd3) ? 2'd2 : op_len;
        state_d = (op_len == 2'd0) ? S_EXEC : S_OPERAND;
      end
      S_OPERAND: begin
        fetch_c = 1'b1;
        if (fetch_ack) begin
          inc_c = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (kind_q)
          K_BRANCH: bl_c = cond_true;
          K_JMP:    jl_c = 1'b1;
          K_JSR: begin
            if (depth_q < MAX_DEPTH) begin
              push    = 1'b1;
              jsl_c   = 1'b1;
              depth_d = depth_q + 4'd1;
            end else begin
              err_d   = 1'b1;
              state_d = S_HALTED;
            end
          end
          K_RTS: begin
            if (depth_q != 4'd0) begin
              pl_c    = 1'b1;
              depth_d = depth_q - 4'd1;
            end else begin
              err_d   = 1'b1;
              state_d = S_HALTED;
            end
          end
          K_HALT:  state_d = S_HALTED;
          default: ;
        endcase
      end
      S_HALTED: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      kind_q  <= K_NEXT;
      cnt_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push && depth_q == 4'(i)) stack_q[i] <= pc;
      end
    end
  end

  // Strobes are gated by reset so an asserted reset can never leak a load.
  assign increment   = inc_c & reset_n;
  assign branch_load = bl_c & reset_n;
  assign jmp_load    = jl_c & reset_n;
  assign jsr_load    = jsl_c & reset_n;
  assign pc_load     = pl_c & reset_n;

  assign branch    = pc + offset;
  assign jmp_addr  = target;
  assign jsr_addr  = target;
  assign pc_addr   = top;
  assign fetch_req = fetch_c;
  assign halted    = (state_q == S_HALTED);
  assign stack_err = err_q;
  assign depth     = depth_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;
  localparam int SD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       fetch_ack = 1'b0;
  logic [2:0] op_kind = '0;
  logic [1:0] op_len = '0;
  logic       cond_true = 1'b0;
  logic [7:0] offset = '0;
  logic [7:0] target = '0;
  logic [7:0] pc = '0;
  logic       increment, branch_load, jmp_load, jsr_load, pc_load;
  logic [7:0] branch, jmp_addr, jsr_addr, pc_addr;
  logic       fetch_req, halted, stack_err;
  logic [3:0] depth;

  pc_sequencer #(.STACK_DEPTH(SD)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_ack(fetch_ack), .op_kind(op_kind),
    .op_len(op_len), .cond_true(cond_true), .offset(offset), .target(target),
    .pc(pc), .increment(increment), .branch_load(branch_load),
    .jmp_load(jmp_load), .jsr_load(jsr_load), .pc_load(pc_load),
    .branch(branch), .jmp_addr(jmp_addr), .jsr_addr(jsr_addr),
    .pc_addr(pc_addr), .fetch_req(fetch_req), .halted(halted),
    .stack_err(stack_err), .depth(depth)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int inc_seen = 0;
  int jsr_seen = 0;

  logic [7:0] m_stack[$];
  logic       m_err = 1'b0;
  logic       m_halted = 1'b0;

  logic       exp_valid = 1'b0;
  logic       e_inc, e_bl, e_jl, e_jsl, e_pl, e_fetch, e_chkfetch, e_halted, e_err;
  logic [7:0] e_addr;
  logic [3:0] e_depth;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("increment", increment, e_inc);
      check("branch_load", branch_load, e_bl);
      check("jmp_load", jmp_load, e_jl);
      check("jsr_load", jsr_load, e_jsl);
      check("pc_load", pc_load, e_pl);
      if (e_chkfetch) check("fetch_req", fetch_req, e_fetch);
      check("halted", halted, e_halted);
      check("stack_err", stack_err, e_err);
      check("depth", depth, e_depth);
      check("strobe_onehot",
            ($countones({increment, branch_load, jmp_load, jsr_load, pc_load}) <= 1), 1);
      if (e_bl)  check("branch", branch, e_addr);
      if (e_jl)  check("jmp_addr", jmp_addr, e_addr);
      if (e_jsl) check("jsr_addr", jsr_addr, e_addr);
      if (e_pl)  check("pc_addr", pc_addr, e_addr);
      inc_seen += int'(increment);
      jsr_seen += int'(jsr_load);
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    fetch_ack  = 1'b0;
    exp_valid  = 1'b1;
    e_inc = 0; e_bl = 0; e_jl = 0; e_jsl = 0; e_pl = 0;
    e_fetch    = 1'b0;
    e_chkfetch = 1'b1;
    e_addr     = '0;
    e_halted   = m_halted;
    e_err      = m_err;
    e_depth    = 4'(m_stack.size());
  endtask

  task automatic do_reset();
    m_stack.delete();
    m_err = 1'b0;
    m_halted = 1'b0;
    repeat (2) begin
      begin_cycle();
      reset_n = 1'b0;
      fetch_ack = 1'b1;
      e_chkfetch = 1'b0;
    end
    begin_cycle();
    reset_n = 1'b1;
    e_fetch = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      begin_cycle();
      fetch_ack = 1'b1;
    end
  endtask

  // One instruction at transaction level: fetch, decode, operand bytes, execute.
  task automatic run_instr(input logic [2:0] kind, input logic [1:0] len, input logic cond,
                           input logic [7:0] off, input logic [7:0] tgt, input logic [7:0] pcv);
    int n;
    logic [2:0] k;
    begin_cycle(); fetch_ack = 1'b1; e_fetch = 1'b1; e_inc = 1'b1;
    begin_cycle(); fetch_ack = 1'b1; op_kind = kind; op_len = len;
    n = (len == 2'd3) ? 2 : int'(len);
    repeat (n) begin
      begin_cycle(); fetch_ack = 1'b1; e_fetch = 1'b1; e_inc = 1'b1;
    end
    begin_cycle();
    fetch_ack = 1'b1; op_kind = 3'd0; op_len = 2'd0;
    cond_true = cond; offset = off; target = tgt; pc = pcv;
    k = (kind > 3'd5) ? 3'd5 : kind;
    case (k)
      3'd1: if (cond) begin e_bl = 1'b1; e_addr = pcv + off; end
      3'd2: begin e_jl = 1'b1; e_addr = tgt; end
      3'd3: begin
        if (m_stack.size() < SD) begin
          e_jsl = 1'b1; e_addr = tgt; m_stack.push_back(pcv);
        end else begin
          m_err = 1'b1; m_halted = 1'b1;
        end
      end
      3'd4: begin
        if (m_stack.size() > 0) begin
          e_pl = 1'b1; e_addr = m_stack[$]; m_stack.pop_back();
        end else begin
          m_err = 1'b1; m_halted = 1'b1;
        end
      end
      3'd5: m_halted = 1'b1;
      default: ;
    endcase
  endtask

  int snap;

  initial begin
    do_reset();
    @(negedge clk);
    check("reset_fetch_req_lit", fetch_req, 1);
    check("reset_depth_lit", depth, 0);

    snap = inc_seen;
    run_instr(3'd0, 2'd2, 1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    check("next_inc_count_lit", inc_seen - snap, 3);
    begin_cycle(); e_fetch = 1'b1;

    run_instr(3'd1, 2'd1, 1'b1, 8'h20, 8'h00, 8'hF0);
    @(negedge clk);
    check("branch_lit", branch, 8'h10);
    check("branch_load_lit", branch_load, 1);
    run_instr(3'd1, 2'd1, 1'b0, 8'h20, 8'h00, 8'hF0);
    run_instr(3'd1, 2'd0, 1'b1, 8'hFE, 8'h00, 8'h01);
    run_instr(3'd2, 2'd3, 1'b0, 8'h00, 8'h77, 8'h33);
    @(negedge clk);
    check("jmp_lit", jmp_addr, 8'h77);

    run_instr(3'd3, 2'd1, 1'b0, 8'h00, 8'h40, 8'h12);
    @(negedge clk);
    check("jsr_addr_lit", jsr_addr, 8'h40);
    run_instr(3'd4, 2'd0, 1'b0, 8'h00, 8'h00, 8'h41);
    @(negedge clk);
    check("rts_depth_before_lit", depth, 1);
    check("rts_pc_addr_lit", pc_addr, 8'h12);
    check("rts_pc_load_lit", pc_load, 1);
    begin_cycle(); e_fetch = 1'b1;
    @(negedge clk);
    check("rts_depth_after_lit", depth, 0);

    run_instr(3'd4, 2'd0, 1'b0, 8'h00, 8'h00, 8'h50);
    idle(3);
    @(negedge clk);
    check("rts_empty_err_lit", stack_err, 1);
    check("rts_empty_halt_lit", halted, 1);

    do_reset();
    snap = jsr_seen;
    for (int i = 0; i < 5; i++)
      run_instr(3'd3, 2'd0, 1'b0, 8'h00, 8'(8'h20 + i), 8'(i + 1));
    idle(2);
    @(negedge clk);
    check("jsr5_loads_lit", jsr_seen - snap, 4);
    check("jsr5_err_lit", stack_err, 1);
    check("jsr5_halt_lit", halted, 1);
    check("jsr5_depth_lit", depth, 4);

    do_reset();
    run_instr(3'd7, 2'd1, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(2);
    @(negedge clk);
    check("halt_kind7_lit", halted, 1);
    check("halt_no_err_lit", stack_err, 0);

    do_reset();
    run_instr(3'd3, 2'd0, 1'b0, 8'h00, 8'h60, 8'h05);
    snap = inc_seen;
    repeat (5) begin begin_cycle(); e_fetch = 1'b1; end
    @(negedge clk);
    check("stall_no_inc_lit", inc_seen - snap, 0);
    begin_cycle(); fetch_ack = 1'b1; e_fetch = 1'b1; e_inc = 1'b1;
    begin_cycle(); fetch_ack = 1'b1; op_kind = 3'd2; op_len = 2'd2;
    begin_cycle(); fetch_ack = 1'b1; e_fetch = 1'b1; e_inc = 1'b1;
    do_reset();
    @(negedge clk);
    check("midop_depth_lit", depth, 0);
    check("midop_fetch_lit", fetch_req, 1);
    run_instr(3'd4, 2'd0, 1'b0, 8'h00, 8'h00, 8'h07);
    idle(1);

    @(negedge clk);
    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, meaning the return-address stack depth (2..8).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fetch_ack  input  1  memory has returned the byte at pc this cycle.
REQ-005 SHALL have port op_kind  input  3  decoded class, sampled in DECODE: 0 NEXT, 1 BRANCH, 2 JMP, 3 JSR, 4 RTS, 5 HALT; 6/7 treated as HALT.
REQ-006 SHALL have port op_len  input  2  operand byte count, sampled in DECODE; value 3 treated as 2.
REQ-007 SHALL have port cond_true  input  1  branch condition, sampled in EXEC.
REQ-008 SHALL have ports offset (8, signed), target (8) and pc (8), all inputs: branch offset, JMP/JSR destination, and current program counter value.
REQ-009 SHALL have ports increment, branch_load, jmp_load, jsr_load and pc_load, each output 1: program-counter control strobes.
REQ-010 SHALL have output ports branch (8), jmp_addr (8), jsr_addr (8) and pc_addr (8): load values.
REQ-011 SHALL have outputs fetch_req (1), halted (1), stack_err (1) and depth (4): fetch request, halted flag, sticky stack error and stack occupancy.

Function
REQ-012 SHALL implement states FETCH, DECODE, OPERAND, EXEC and HALTED.
REQ-013 In FETCH, fetch_req SHALL be 1; on fetch_ack, increment=1 that cycle and next state=DECODE; otherwise the FSM SHALL stay in FETCH.
REQ-014 In DECODE, the FSM SHALL latch op_kind, go to OPERAND with remaining count=op_len if op_len>0, and otherwise go to EXEC.
REQ-015 In OPERAND, fetch_req SHALL be 1; each fetch_ack SHALL pulse increment and decrement the count; the FSM SHALL go to EXEC when the count reaches 0.
REQ-016 EXEC SHALL last exactly 1 cycle, then go to FETCH unless REQ-021/022/023 applies.
REQ-017 In EXEC with BRANCH and cond_true=1, branch_load=1 and branch=(pc + sign-extended offset) mod 256; with cond_true=0, no strobe SHALL be asserted.
REQ-018 In EXEC with JMP, jmp_load=1 and jmp_addr=target.
REQ-019 In EXEC with JSR and depth<STACK_DEPTH, pc SHALL be pushed, depth incremented, jsr_load=1 and jsr_addr=target.
REQ-020 In EXEC with RTS and depth>0, the top entry SHALL be popped into pc_addr, pc_load=1 and depth decremented.
REQ-021 JSR with a full stack SHALL cause no push and no load, SHALL set stack_err, and SHALL go to HALTED.
REQ-022 RTS with an empty stack SHALL cause no pop and no load, SHALL set stack_err, and SHALL go to HALTED.
REQ-023 HALT in EXEC SHALL assert no strobe and go to HALTED.
REQ-024 HALTED SHALL be left only by reset; halted=1 and all strobes and fetch_req SHALL be 0 while in it.
REQ-025 At most one of increment, branch_load, jmp_load, jsr_load and pc_load SHALL be 1 in any cycle.
REQ-026 NEXT in EXEC SHALL assert no strobe; the sequence NEXT with op_len=0 SHALL take 3 cycles: FETCH, DECODE, EXEC.
REQ-027 The address outputs SHALL be registered or combinational but stable and valid whenever their strobe is 1; otherwise they are don't-care.
REQ-028 pc arithmetic SHALL wrap modulo 256 with no error.

Reset
REQ-029 On reset_n=0, state SHALL be FETCH, depth=0, stack_err=0 and halted=0, all strobes SHALL be 0, and fetch_req SHALL be 1 after deassertion.
REQ-030 Reset asserted mid-OPERAND or mid-EXEC SHALL abort immediately with no strobe, and stack contents SHALL be discarded.

Verification
REQ-031 The bench SHALL cover: NEXT, op_len=2, fetch_ack each cycle -> increment pulses in 3 cycles, one EXEC cycle with no strobe, then FETCH.
REQ-032 The bench SHALL cover: BRANCH, pc=0xF0, offset=0x20, cond_true=1 -> branch_load=1, branch=0x10; with cond_true=0 -> no strobe.
REQ-033 The bench SHALL cover: JSR target=0x40 at pc=0x12, then RTS -> jsr_addr=0x40 and depth 1, then pc_addr=0x12, pc_load=1 and depth 0.
REQ-034 The bench SHALL cover: 5 JSRs with STACK_DEPTH=4 -> the 5th gives stack_err=1, halted=1 and no jsr_load.
REQ-035 The bench SHALL cover: RTS at depth 0 -> stack_err=1, halted=1 and no pc_load.
REQ-036 The bench SHALL cover: fetch_ack held 0 for 5 cycles, then reset pulsed during OPERAND -> no increment, and post-reset state FETCH with depth=0.
